// File: rtl/data_split.sv
// Byte-stream to parallel-sample reassembler: packs NBYTES input beats into N_PRL samples of BW
// bits, holds one spare word under back-pressure, and discards and counts runt frames.
module data_split #(
  parameter int unsigned BW     = 18,
  parameter int unsigned N_PRL  = 4,
  parameter int unsigned BW_out = 8,
  parameter int unsigned ERR_W  = 16
) (
  input  logic                        clk,
  input  logic                        srst_n,
  input  logic [BW_out-1:0]           s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
  output logic                        s_ready,
  output logic [N_PRL-1:0][BW-1:0]    y,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic                        y_last,
  output logic                        runt_err,
  output logic [ERR_W-1:0]            err_cnt
);

  localparam int unsigned WordW  = BW * N_PRL;
  localparam int unsigned NBytes = WordW / BW_out;
  localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WordW-1:0] acc_q, acc_d;
  logic             acc_full_q, acc_full_d;
  logic             acc_last_q, acc_last_d;
  logic [WordW-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             y_last_q, y_last_d;
  logic             runt_q, runt_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic             beat;
  logic             is_final;
  logic             slot_free;
  logic             load;
  logic [WordW-1:0] acc_ins;

  // Only the spare-word flag gates input, so s_ready comes straight from a register.
  assign s_ready   = ~acc_full_q;
  assign beat      = s_valid & s_ready;
  assign is_final  = (idx_q == IdxW'(NBytes - 1));
  assign slot_free = ~y_valid_q | y_ready;

  always_comb begin
    acc_ins = acc_q;
    acc_ins[idx_q * BW_out +: BW_out] = s_data;
  end

  always_comb begin
    idx_d      = idx_q;
    acc_d      = acc_q;
    acc_full_d = acc_full_q;
    acc_last_d = acc_last_q;
    y_d        = y_q;
    y_valid_d  = y_valid_q;
    y_last_d   = y_last_q;
    runt_d     = 1'b0;
    cnt_d      = cnt_q;
    load       = 1'b0;

    if (acc_full_q) begin
      // Spare word waits for the first free output slot.
      if (y_ready) begin
        y_d        = acc_q;
        y_valid_d  = 1'b1;
        y_last_d   = acc_last_q;
        acc_full_d = 1'b0;
        load       = 1'b1;
      end
    end else if (beat) begin
      if (is_final) begin
        idx_d = '0;
        if (slot_free) begin
          y_d       = acc_ins;
          y_valid_d = 1'b1;
          y_last_d  = s_last;
          load      = 1'b1;
        end else begin
          acc_d      = acc_ins;
          acc_full_d = 1'b1;
          acc_last_d = s_last;
        end
      end else if (s_last) begin
        idx_d  = '0;
        runt_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + ERR_W'(1);
        end
      end else begin
        acc_d = acc_ins;
        idx_d = idx_q + IdxW'(1);
      end
    end

    if (!load && y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
      y_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      idx_q      <= '0;
      acc_q      <= '0;
      acc_full_q <= 1'b0;
      acc_last_q <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      y_last_q   <= 1'b0;
      runt_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      acc_full_q <= acc_full_d;
      acc_last_q <= acc_last_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      y_last_q   <= y_last_d;
      runt_q     <= runt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign y        = y_q;
  assign y_valid  = y_valid_q;
  assign y_last   = y_last_q;
  assign runt_err = runt_q;
  assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_data_split.sv
// Scoreboard bench for data_split: a byte-list model predicts words and runts; a negedge
// monitor compares every output handshake. A second instance with a 2-bit counter checks saturation.
module tb_data_split;
  localparam int BW = 18, N_PRL = 4, BW_OUT = 8, NB = 9, WW = 72;

  logic clk = 1'b0, srst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic s_valid = 1'b0, s_last = 1'b0, y_ready = 1'b1;
  logic s_ready, y_valid, y_last, runt_err;
  logic [N_PRL-1:0][BW-1:0] y;
  logic [15:0] err_cnt;
  logic s_ready2, y_valid2, y_last2, runt_err2;
  logic [N_PRL-1:0][BW-1:0] y2;
  logic [1:0] err_cnt2;

  always #5 clk = ~clk;

  data_split #(.BW(BW), .N_PRL(N_PRL), .BW_out(BW_OUT), .ERR_W(16)) dut (
    .clk(clk), .srst_n(srst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_last(y_last),
    .runt_err(runt_err), .err_cnt(err_cnt));

  data_split #(.BW(BW), .N_PRL(N_PRL), .BW_out(BW_OUT), .ERR_W(2)) dut2 (
    .clk(clk), .srst_n(srst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready2), .y(y2), .y_valid(y_valid2), .y_ready(y_ready), .y_last(y_last2),
    .runt_err(runt_err2), .err_cnt(err_cnt2));

  typedef struct {logic [WW-1:0] w; logic l;} exp_t;
  exp_t expq[$];
  logic [7:0] cur[$];
  int total = 0, bad = 0;
  int exp_runts = 0, exp_pulses = 0, runt_seen = 0, runt_seen2 = 0;
  int cyc = 0, sready_drop = 0;
  int hs_cyc[$];
  bit stream_win = 0, rnd_rdy = 0;
  logic [WW-1:0] last_y = '0;
  logic last_l = 1'b0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: collect bytes; NB bytes form a word (byte k at bit 8k), s_last earlier is a runt.
  task automatic model_beat(input logic [7:0] d, input logic l);
    logic [WW-1:0] v;
    cur.push_back(d);
    if (cur.size() == NB) begin
      for (int k = 0; k < NB; k++) v[8*k +: 8] = cur[k];
      expq.push_back('{w: v, l: l});
      cur.delete();
    end else if (l) begin
      cur.delete();
      exp_runts++;
      exp_pulses++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    bit ok = 0;
    s_data = d; s_valid = 1'b1; s_last = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (ok) model_beat(d, l);
    else begin
      total++; bad++;
      $display("FAIL send_timeout: got s_ready=0 for %0d cycles expected 1", n);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (expq.size() != 0 && n < 500) begin
      idle(1);
      n++;
    end
    chk("drain_pending", WW'(expq.size()), '0);
  endtask

  task automatic send_word_seq(input logic l);
    for (int i = 1; i <= NB; i++) send_byte(8'(i), (i == NB) ? l : 1'b0);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) if (rnd_rdy) begin
    #1;
    if (rnd_rdy) y_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (srst_n) begin
      if (y_valid && y_ready) begin
        if (expq.size() == 0) begin
          total++; bad++;
          $display("FAIL y_unexpected: got word %h expected none", y);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("y_word", y, e.w);
          chk("y_last", WW'(y_last), WW'(e.l));
        end
        last_y = y;
        last_l = y_last;
        hs_cyc.push_back(cyc);
      end
      if (runt_err) runt_seen++;
      if (runt_err2) runt_seen2++;
      if (stream_win && !s_ready) sready_drop++;
    end
  end

  initial begin
    #2;
    chk("rst_y_valid", WW'(y_valid), '0);
    chk("rst_y", y, '0);
    chk("rst_err_cnt", WW'(err_cnt), '0);
    chk("rst_runt_err", WW'(runt_err), '0);
    @(negedge clk);
    srst_n = 1'b1;
    idle(1);
    chk("rst_s_ready", WW'(s_ready), WW'(1));

    // Single word with latency check
    send_word_seq(1'b1);
    chk("single_latency", WW'(y_valid), WW'(1));
    idle(1);
    chk("single_drop", WW'(y_valid), '0);
    chk("single_s0", WW'(last_y[17:0]), WW'(18'h30201));
    chk("single_s1", WW'(last_y[35:18]), WW'(18'h14100));
    chk("single_last", WW'(last_l), WW'(1));

    // Back-pressure: two words, second parked in the spare slot
    y_ready = 1'b0;
    for (int i = 0; i < 2 * NB; i++) send_byte(8'($urandom), i == 2 * NB - 1);
    chk("bp_s_ready_low", WW'(s_ready), '0);
    chk("bp_y_valid", WW'(y_valid), WW'(1));
    y_ready = 1'b1;
    idle(1);
    y_ready = 1'b0;
    chk("bp_s_ready_back", WW'(s_ready), WW'(1));
    chk("bp_word2_valid", WW'(y_valid), WW'(1));
    idle(2);
    y_ready = 1'b1;
    wait_drain();
    idle(2);

    // Runt then a good word
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 4);
    idle(2);
    chk("runt_err_cnt", WW'(err_cnt), WW'(sat(exp_runts, 65535)));
    chk("runt_no_valid", WW'(y_valid), '0);
    for (int i = 0; i < NB; i++) send_byte(8'($urandom), i == NB - 1);
    wait_drain();
    idle(2);

    // Reset mid-word
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    srst_n = 1'b0;
    cur.delete();
    exp_runts = 0;
    idle(1);
    chk("mid_rst_valid", WW'(y_valid), '0);
    srst_n = 1'b1;
    idle(1);
    chk("mid_rst_err_cnt", WW'(err_cnt), '0);
    chk("mid_rst_err_cnt2", WW'(err_cnt2), '0);
    chk("mid_rst_s_ready", WW'(s_ready), WW'(1));
    send_word_seq(1'b1);
    idle(1);
    chk("mid_rst_s0", WW'(last_y[17:0]), WW'(18'h30201));
    chk("mid_rst_s1", WW'(last_y[35:18]), WW'(18'h14100));
    chk("mid_rst_err_after", WW'(err_cnt), '0);
    idle(2);

    // Streaming: 27 bytes back-to-back
    hs_cyc.delete();
    sready_drop = 0;
    stream_win = 1;
    for (int i = 0; i < 3 * NB; i++) send_byte(8'($urandom), i == 3 * NB - 1);
    idle(3);
    stream_win = 0;
    chk("stream_words", WW'(hs_cyc.size()), WW'(3));
    if (hs_cyc.size() == 3) begin
      chk("stream_gap1", WW'(hs_cyc[1] - hs_cyc[0]), WW'(NB));
      chk("stream_gap2", WW'(hs_cyc[2] - hs_cyc[1]), WW'(NB));
    end
    chk("stream_s_ready", WW'(sready_drop), '0);

    // Saturation: five runts of assorted lengths
    for (int r = 0; r < 5; r++) begin
      int len = $urandom_range(1, NB - 1);
      for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1);
    end
    idle(2);
    chk("sat_err_cnt16", WW'(err_cnt), WW'(sat(exp_runts, 65535)));
    chk("sat_err_cnt2", WW'(err_cnt2), WW'(sat(exp_runts, 3)));

    // Randomized frames, gaps and back-pressure
    rnd_rdy = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, NB - 1);
      else len = NB * $urandom_range(1, 3);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send_byte(8'($urandom), i == len - 1);
      end
    end
    rnd_rdy = 0;
    #2;
    y_ready = 1'b1;
    wait_drain();
    idle(3);
    chk("end_runt_pulses", WW'(runt_seen), WW'(exp_pulses));
    chk("end_runt_pulses2", WW'(runt_seen2), WW'(exp_pulses));
    chk("end_err_cnt16", WW'(err_cnt), WW'(sat(exp_runts, 65535)));
    chk("end_err_cnt2", WW'(err_cnt2), WW'(sat(exp_runts, 3)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
